// File: rtl/reset_sequencer.sv
// reset_sequencer
// Orders and stretches the MKIO core, transmitter and receiver resets behind the
// synchronized board reset. All three resets are held until the PLL locks, then
// released core -> TX -> RX with a fixed gap between each release. Loss of lock or a
// software request re-enters HOLD. Repeated lock timeouts latch FAULT until a
// software request or a board reset clears it.
//
// The edge on which rst_n is first sampled high still behaves as a reset edge. That
// edge is therefore the HOLD entry edge, and WAIT_LOCK is reached HOLD_CYC edges
// later. This matches the HOLD timing used after a soft request or a lock loss.

module reset_sequencer #(
  parameter int HOLD_CYC     = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int STEP_CYC     = 8,
  parameter int RETRY_MAX    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       core_rst,
  output logic       tx_rst,
  output logic       rx_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam int MAX_HL  = (HOLD_CYC > LOCK_TIMEOUT) ? HOLD_CYC : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_HL > STEP_CYC) ? MAX_HL : STEP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int RTY_W   = $clog2(RETRY_MAX) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(RETRY_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RTY_W-1:0] RTY_ZERO  = {RTY_W{1'b0}};
  localparam logic [RTY_W-1:0] RTY_ONE   = {{(RTY_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_REL_CORE  = 3'd2,
    ST_REL_TX    = 3'd3,
    ST_REL_RX    = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [RTY_W-1:0] retry_cnt;
  logic [RTY_W-1:0] retry_nxt;
  logic [RTY_W-1:0] retry_inc;
  logic             rst_q;
  logic             lock_lost;
  logic             core_rst_nxt;
  logic             tx_rst_nxt;
  logic             rx_rst_nxt;
  logic             ready_nxt;
  logic             fault_nxt;

  assign state_o   = state;
  assign retry_inc = retry_cnt + RTY_ONE;

  // Remember whether rst_n was high on the previous edge so the release edge acts as reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_q <= 1'b0;
    end else begin
      rst_q <= 1'b1;
    end
  end

  // Lock loss only matters once at least one reset has been released.
  always_comb begin
    lock_lost = 1'b0;
    case (state)
      ST_REL_CORE,
      ST_REL_TX,
      ST_REL_RX,
      ST_RUN:  lock_lost = ~pll_locked;
      default: lock_lost = 1'b0;
    endcase
  end

  // Next-state, counter and retry logic; soft request beats lock loss beats timers.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    if (soft_rst_req) begin
      state_nxt = ST_HOLD;
      cnt_nxt   = CNT_ZERO;
      retry_nxt = RTY_ZERO;
    end else if (lock_lost) begin
      state_nxt = ST_HOLD;
      cnt_nxt   = CNT_ZERO;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = CNT_ZERO;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (pll_locked) begin
            state_nxt = ST_REL_CORE;
            cnt_nxt   = CNT_ZERO;
          end else if (cnt == LOCK_LAST) begin
            retry_nxt = retry_inc;
            cnt_nxt   = CNT_ZERO;
            if (retry_inc == RTY_LIMIT) begin
              state_nxt = ST_FAULT;
            end else begin
              state_nxt = ST_HOLD;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_REL_CORE: begin
          if (cnt == STEP_LAST) begin
            state_nxt = ST_REL_TX;
            cnt_nxt   = CNT_ZERO;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_REL_TX: begin
          if (cnt == STEP_LAST) begin
            state_nxt = ST_REL_RX;
            cnt_nxt   = CNT_ZERO;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_REL_RX: begin
          if (cnt == STEP_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = CNT_ZERO;
            retry_nxt = RTY_ZERO;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          state_nxt = ST_RUN;
          cnt_nxt   = CNT_ZERO;
        end
        ST_FAULT: begin
          state_nxt = ST_FAULT;
          cnt_nxt   = CNT_ZERO;
        end
        default: begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // Decode the outputs from the next state so they update on the same edge as state.
  always_comb begin
    core_rst_nxt = 1'b1;
    tx_rst_nxt   = 1'b1;
    rx_rst_nxt   = 1'b1;
    ready_nxt    = 1'b0;
    fault_nxt    = 1'b0;
    case (state_nxt)
      ST_REL_CORE: begin
        core_rst_nxt = 1'b0;
      end
      ST_REL_TX: begin
        core_rst_nxt = 1'b0;
        tx_rst_nxt   = 1'b0;
      end
      ST_REL_RX: begin
        core_rst_nxt = 1'b0;
        tx_rst_nxt   = 1'b0;
        rx_rst_nxt   = 1'b0;
      end
      ST_RUN: begin
        core_rst_nxt = 1'b0;
        tx_rst_nxt   = 1'b0;
        rx_rst_nxt   = 1'b0;
        ready_nxt    = 1'b1;
      end
      ST_FAULT: begin
        fault_nxt = 1'b1;
      end
      default: begin
        core_rst_nxt = 1'b1;
        tx_rst_nxt   = 1'b1;
        rx_rst_nxt   = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs; the rst_n release edge is still a reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n || !rst_q) begin
      state     <= ST_HOLD;
      cnt       <= CNT_ZERO;
      retry_cnt <= RTY_ZERO;
      core_rst  <= 1'b1;
      tx_rst    <= 1'b1;
      rx_rst    <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      core_rst  <= core_rst_nxt;
      tx_rst    <= tx_rst_nxt;
      rx_rst    <= rx_rst_nxt;
      ready     <= ready_nxt;
      fault     <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed scenarios plus randomized lock/soft/reset traffic, checked every edge
// against a phase/elapsed-time model of the reset sequencer.

module tb_reset_sequencer;

  localparam int HOLD_CYC     = 16;
  localparam int LOCK_TIMEOUT = 16;
  localparam int STEP_CYC     = 8;
  localparam int RETRY_MAX    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       core_rst;
  logic       tx_rst;
  logic       rx_rst;
  logic       ready;
  logic       fault;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  // Model: phase 0..6 as named in the state list, edges elapsed in that phase, retries.
  int   m_phase = 0;
  int   m_age = 0;
  int   m_retries = 0;
  logic m_prev_rst_n = 1'b0;

  reset_sequencer #(
    .HOLD_CYC    (HOLD_CYC),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STEP_CYC    (STEP_CYC),
    .RETRY_MAX   (RETRY_MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .soft_rst_req(soft_rst_req),
    .core_rst    (core_rst),
    .tx_rst      (tx_rst),
    .rx_rst      (rx_rst),
    .ready       (ready),
    .fault       (fault),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance the model by one edge using the inputs the DUT samples on that edge.
  // The release edge of rst_n counts as HOLD entry, so WAIT_LOCK follows HOLD_CYC edges later.
  task automatic model_step();
    if (!rst_n || !m_prev_rst_n) begin
      m_phase = 0; m_age = 0; m_retries = 0;
    end else if (soft_rst_req) begin
      m_phase = 0; m_age = 0; m_retries = 0;
    end else if (m_phase >= 2 && m_phase <= 5 && !pll_locked) begin
      m_phase = 0; m_age = 0;
    end else if (m_phase == 0) begin
      m_age++;
      if (m_age == HOLD_CYC) begin m_phase = 1; m_age = 0; end
    end else if (m_phase == 1) begin
      if (pll_locked) begin
        m_phase = 2; m_age = 0;
      end else begin
        m_age++;
        if (m_age == LOCK_TIMEOUT) begin
          m_retries++;
          m_phase = (m_retries == RETRY_MAX) ? 6 : 0;
          m_age = 0;
        end
      end
    end else if (m_phase >= 2 && m_phase <= 4) begin
      m_age++;
      if (m_age == STEP_CYC) begin
        m_phase++; m_age = 0;
        if (m_phase == 5) m_retries = 0;
      end
    end
    m_prev_rst_n = rst_n;
  endtask

  function automatic logic [7:0] model_outputs();
    logic [2:0] st;
    logic c, t, r, rd, f;
    st = m_phase[2:0];
    c  = !(m_phase >= 2 && m_phase <= 5);
    t  = !(m_phase >= 3 && m_phase <= 5);
    r  = !(m_phase >= 4 && m_phase <= 5);
    rd = (m_phase == 5);
    f  = (m_phase == 6);
    return {st, c, t, r, rd, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("outputs_vs_model", {24'd0, state_o, core_rst, tx_rst, rx_rst, ready, fault},
          {24'd0, model_outputs()});
  endtask

  // Time each release relative to the HOLD entry edge; off=0 means the first tick is entry.
  task automatic measure(input string tag, input int off);
    int t_wait = -1, t_core = -1, t_tx = -1, t_rx = -1, t_rdy = -1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (t_wait < 0 && state_o == 3'd1) t_wait = n;
      if (t_core < 0 && !core_rst) t_core = n;
      if (t_tx < 0 && !tx_rst) t_tx = n;
      if (t_rx < 0 && !rx_rst) t_rx = n;
      if (t_rdy < 0 && ready) t_rdy = n;
    end
    check({tag, "_wait_lock_edge"}, t_wait, HOLD_CYC - off);
    check({tag, "_core_rst_fall"}, t_core, HOLD_CYC + 1 - off);
    check({tag, "_tx_rst_fall"}, t_tx, HOLD_CYC + 1 + STEP_CYC - off);
    check({tag, "_rx_rst_fall"}, t_rx, HOLD_CYC + 1 + 2 * STEP_CYC - off);
    check({tag, "_ready_rise"}, t_rdy, HOLD_CYC + 1 + 3 * STEP_CYC - off);
  endtask

  task automatic wait_fault(input string tag, input int exp);
    int found = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (fault) begin found = i; break; end
    end
    check(tag, found, exp);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st);
    int found = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (state_o == st) begin found = i; break; end
    end
    check({tag, "_reached"}, (found >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int mode;
    // 1: reset values, then release with lock held high.
    rst_n = 1'b0; pll_locked = 1'b1; soft_rst_req = 1'b0;
    repeat (3) tick();
    check("s1_reset_values", {24'd0, state_o, core_rst, tx_rst, rx_rst, ready, fault},
          {24'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;
    measure("s1", 0);
    check("s1_run_state", {29'd0, state_o}, 32'd5);

    // 2: lock lost for good -> three HOLD/WAIT_LOCK loops then FAULT.
    pll_locked = 1'b0;
    wait_fault("s2_fault_edge", RETRY_MAX * (HOLD_CYC + LOCK_TIMEOUT));
    check("s2_fault_state", {29'd0, state_o}, 32'd6);
    check("s2_fault_resets", {29'd0, core_rst, tx_rst, rx_rst}, 32'd7);
    repeat (5) tick();
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
    check("s2_soft_exit", {29'd0, state_o, fault}, 32'd0);

    // 3: one-cycle lock drop in RUN, sequence repeats with the same timing.
    pll_locked = 1'b1;
    measure("s3a", 1);
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    check("s3_drop_state", {29'd0, state_o}, 32'd0);
    check("s3_drop_ready_resets", {28'd0, ready, core_rst, tx_rst, rx_rst}, 32'd7);
    measure("s3b", 1);

    // 4: soft request and lock loss together in REL_TX; soft wins and clears retries.
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
    wait_state("s4_rel_tx", 3'd3);
    soft_rst_req = 1'b1; pll_locked = 1'b0; tick(); soft_rst_req = 1'b0;
    check("s4_hold", {29'd0, state_o}, 32'd0);
    wait_fault("s4_full_retry_budget", RETRY_MAX * (HOLD_CYC + LOCK_TIMEOUT) - 1);

    // 5: one-cycle rst_n pulse in REL_RX, then full restart from edge 0.
    pll_locked = 1'b1;
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
    wait_state("s5_rel_rx", 3'd4);
    rst_n = 1'b0; tick();
    check("s5_reset_values", {24'd0, state_o, core_rst, tx_rst, rx_rst, ready, fault},
          {24'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;
    measure("s5", 0);

    // 6: lock arrives on the final WAIT_LOCK cycle; no retry is charged.
    soft_rst_req = 1'b1; pll_locked = 1'b0; tick(); soft_rst_req = 1'b0;
    repeat (HOLD_CYC + LOCK_TIMEOUT - 1) tick();
    check("s6_still_waiting", {29'd0, state_o}, 32'd1);
    pll_locked = 1'b1; tick();
    check("s6_rel_core", {29'd0, state_o}, 32'd2);
    check("s6_no_fault", {31'd0, fault}, 32'd0);
    pll_locked = 1'b0; tick();
    wait_fault("s6_retry_not_charged", RETRY_MAX * (HOLD_CYC + LOCK_TIMEOUT) - 1);

    // Randomized traffic in segments of mostly-locked and mostly-unlocked behaviour.
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
    for (int seg = 0; seg < 20; seg++) begin
      mode = int'($urandom_range(0, 1));
      for (int i = 0; i < 200; i++) begin
        if (mode == 0) pll_locked = ($urandom_range(0, 99) < 99);
        else           pll_locked = ($urandom_range(0, 99) < 8);
        soft_rst_req = ($urandom_range(0, 999) < 4);
        rst_n        = !($urandom_range(0, 1999) < 2);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
